// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit memory master.
//   - LDST_* : access-size codes (RISC-V funct3 encoding of loads/stores)
//   - lsu_state_t : bus-master FSM states
//   - BE_ALL : byte-enable mask used for every load
//   - helper functions for legality, store byte enables and store data
// ---------------------------------------------------------------------------
package lsu_pkg;

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   localparam logic [3:0] BE_ALL = 4'hF;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } lsu_state_t;

   // An access is legal when the size code exists, the unsigned variants are
   // only used for loads, and the address is naturally aligned.
   function automatic logic lsu_legal(input logic       we,
                                      input logic [2:0] size,
                                      input logic [1:0] off);
      logic ok;
      ok = 1'b0;
      case (size)
         LDST_B:  ok = 1'b1;
         LDST_H:  ok = (off[0] == 1'b0);
         LDST_W:  ok = (off == 2'b00);
         LDST_BU: ok = !we;
         LDST_HU: ok = !we && (off[0] == 1'b0);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Byte enables for a store; only meaningful for legal store sizes.
   function automatic logic [3:0] lsu_store_be(input logic [2:0] size,
                                               input logic [1:0] off);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         LDST_B:  be = 4'b0001 << off;
         LDST_H:  be = off[1] ? 4'b1100 : 4'b0011;
         LDST_W:  be = BE_ALL;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Store data is replicated across every lane so the memory can pick the
   // lanes it needs using the byte enables alone.
   function automatic logic [31:0] lsu_store_wd(input logic [2:0]  size,
                                                input logic [31:0] wd);
      logic [31:0] d;
      d = 32'h0;
      case (size)
         LDST_B:  d = {4{wd[7:0]}};
         LDST_H:  d = {2{wd[15:0]}};
         LDST_W:  d = wd;
         default: d = 32'h0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align
//   Purely combinational load-data aligner. Picks the addressed byte or
//   half-word out of the memory read word and sign- or zero-extends it.
//   Ports:
//     mem_rd_i [31:0] : raw read word from the data memory
//     off_i    [1:0]  : byte offset of the access within the word
//     size_i   [2:0]  : load size code (LDST_*)
//     rd_o     [31:0] : aligned, extended load result (0 for non-load codes)
// ---------------------------------------------------------------------------
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] mem_rd_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  size_i,
   output logic [31:0] rd_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = mem_rd_i[{off_i, 3'b000} +: 8];
      half_v = mem_rd_i[{off_i[1], 4'b0000} +: 16];
      rd_o   = 32'h0;
      case (size_i)
         LDST_B:  rd_o = {{24{byte_v[7]}}, byte_v};
         LDST_H:  rd_o = {{16{half_v[15]}}, half_v};
         LDST_W:  rd_o = mem_rd_i;
         LDST_BU: rd_o = {24'h0, byte_v};
         LDST_HU: rd_o = {16'h0, half_v};
         default: rd_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// ---------------------------------------------------------------------------
// lsu_mem_master
//   Initiator side of the external data-memory interface. Turns a core
//   load/store request into a word-addressed memory transaction with byte
//   enables and lane-replicated write data, then aligns/extends read data.
//
//   Handshake: the core raises core_req_i and holds every request field
//   stable while core_stall_o=1; the request is accepted at the first rising
//   edge where core_stall_o=0. On the memory side mem_req_o and its fields
//   stay constant from the issuing cycle until the cycle in which
//   mem_ready_i=1, which is the completing cycle (read data valid then).
//
//   Ports:
//     clk_i, rst_i            : clock, synchronous active-high reset
//     core_req_i/we/size/addr/wd : core request
//     core_rd_o               : load result, valid in the completing cycle
//     core_stall_o            : core must hold and not advance
//     core_err_o              : one-cycle pulse on misaligned/illegal access
//     mem_req_o/we/be/addr/wd : memory request
//     mem_rd_i, mem_ready_i   : memory read word and ready
// ---------------------------------------------------------------------------
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                core_req_i,
   input  logic                core_we_i,
   input  logic [2:0]          core_size_i,
   input  logic [ADDR_W-1:0]   core_addr_i,
   input  logic [DATA_W-1:0]   core_wd_i,
   output logic [DATA_W-1:0]   core_rd_o,
   output logic                core_stall_o,
   output logic                core_err_o,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wd_o,
   input  logic [DATA_W-1:0]   mem_rd_i,
   input  logic                mem_ready_i
);

   lsu_state_t state_q, state_d;
   logic [1:0] off_q, off_d;
   logic [2:0] size_q, size_d;

   logic        legal;
   logic        drive_mem;
   logic [31:0] align_rd;

   assign legal = lsu_legal(core_we_i, core_size_i, core_addr_i[1:0]);

   // The aligner uses the offset/size captured at issue, not the live inputs.
   lsu_load_align u_align (
      .mem_rd_i (mem_rd_i),
      .off_i    (off_q),
      .size_i   (size_q),
      .rd_o     (align_rd)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         off_q   <= 2'b00;
         size_q  <= 3'b000;
      end else begin
         state_q <= state_d;
         off_q   <= off_d;
         size_q  <= size_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      off_d        = off_q;
      size_d       = size_q;
      drive_mem    = 1'b0;
      core_stall_o = 1'b0;
      core_err_o   = 1'b0;
      core_rd_o    = '0;

      if (!rst_i) begin
         case (state_q)
            IDLE: begin
               if (core_req_i) begin
                  if (legal) begin
                     drive_mem    = 1'b1;
                     core_stall_o = 1'b1;
                     off_d        = core_addr_i[1:0];
                     size_d       = core_size_i;
                     state_d      = WAIT;
                  end else begin
                     // Illegal access retires immediately with an error.
                     core_err_o = 1'b1;
                  end
               end
            end
            WAIT: begin
               if (!core_req_i) begin
                  // Core abandoned the request: drop the bus and go idle.
                  state_d = IDLE;
               end else begin
                  drive_mem = 1'b1;
                  if (mem_ready_i) begin
                     state_d = IDLE;
                     if (!core_we_i) begin
                        core_rd_o = align_rd;
                     end
                  end else begin
                     core_stall_o = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Memory fields are derived from the held core request, so they stay
   // constant across the whole transaction without extra registers.
   always_comb begin
      mem_req_o  = 1'b0;
      mem_we_o   = 1'b0;
      mem_be_o   = '0;
      mem_addr_o = '0;
      mem_wd_o   = '0;
      if (drive_mem) begin
         mem_req_o  = 1'b1;
         mem_we_o   = core_we_i;
         mem_be_o   = core_we_i ? lsu_store_be(core_size_i, core_addr_i[1:0]) : BE_ALL;
         mem_addr_o = core_addr_i;
         mem_wd_o   = core_we_i ? lsu_store_wd(core_size_i, core_wd_i) : '0;
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;
   import lsu_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        core_req, core_we;
   logic [2:0]  core_size;
   logic [31:0] core_addr, core_wd;
   logic [31:0] core_rd;
   logic        core_stall, core_err;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wd;
   logic [31:0] mem_rd;
   logic        mem_ready;

   lsu_mem_master #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .core_req_i   (core_req),
      .core_we_i    (core_we),
      .core_size_i  (core_size),
      .core_addr_i  (core_addr),
      .core_wd_i    (core_wd),
      .core_rd_o    (core_rd),
      .core_stall_o (core_stall),
      .core_err_o   (core_err),
      .mem_req_o    (mem_req),
      .mem_we_o     (mem_we),
      .mem_be_o     (mem_be),
      .mem_addr_o   (mem_addr),
      .mem_wd_o     (mem_wd),
      .mem_rd_i     (mem_rd),
      .mem_ready_i  (mem_ready)
   );

   // ---------------- reference model (byte-addressed) ----------------
   logic [7:0] ref_mem [0:255];

   function automatic int nbytes(input logic [2:0] size);
      if (size[1:0] == 2'd0) return 1;
      if (size[1:0] == 2'd1) return 2;
      return 4;
   endfunction

   function automatic logic ref_legal(input logic we, input logic [2:0] size, input int addr);
      if (size == 3'd3 || size == 3'd6 || size == 3'd7) return 1'b0;
      if (we && size >= 3'd4) return 1'b0;
      return (addr % nbytes(size)) == 0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] size, input int addr);
      int n;
      logic [31:0] v;
      n = nbytes(size);
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
      if (size < 3'd4 && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      return v;
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] size, input int addr);
      logic [3:0] be;
      be = 4'h0;
      for (int i = 0; i < nbytes(size); i++) be = be | (4'd1 << ((addr % 4) + i));
      return be;
   endfunction

   function automatic logic [31:0] ref_wd(input logic [2:0] size, input logic [31:0] wd);
      if (nbytes(size) == 1) return {24'h0, wd[7:0]} * 32'h0101_0101;
      if (nbytes(size) == 2) return {16'h0, wd[15:0]} * 32'h0001_0001;
      return wd;
   endfunction

   task automatic ref_store(input logic [2:0] size, input int addr, input logic [31:0] wd);
      for (int i = 0; i < nbytes(size); i++) ref_mem[addr + i] = 8'(wd >> (8 * i));
   endtask

   // ---------------- memory model (registered read) ----------------
   logic [31:0] mem_arr [0:63];
   always @(posedge clk) begin
      if (rst) begin
         for (int w = 0; w < 64; w++)
            mem_arr[w] <= {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
      end else if (mem_req) begin
         if (mem_we)
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) mem_arr[mem_addr[7:2]][8*b +: 8] <= mem_wd[8*b +: 8];
         mem_rd <= mem_arr[mem_addr[7:2]];
      end
   end

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Called just after a rising edge; returns just after the edge at which
   // the core would advance.
   task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, input int stalls,
                            output logic [31:0] rd, output logic err, output int stall_cyc,
                            output int req_cyc, output logic [3:0] be, output logic [31:0] wdo,
                            output logic we_bad, output logic timeout);
      int  n;
      logic done;
      core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
      rd = 32'h0; err = 1'b0; stall_cyc = 0; req_cyc = 0; be = 4'h0; wdo = 32'h0;
      we_bad = 1'b0; done = 1'b0; n = 0;
      while (!done && n < 40) begin
         mem_ready = (n >= 1 && n <= stalls) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (core_err) err = 1'b1;
         if (core_stall) stall_cyc++;
         if (mem_req) begin
            req_cyc++;
            be  = mem_be;
            wdo = mem_wd;
            if (mem_we !== we) we_bad = 1'b1;
         end
         if (!core_stall) begin
            rd   = core_rd;
            done = 1'b1;
         end
         @(posedge clk); #1;
         n++;
      end
      timeout = !done;
      core_req = 1'b0; mem_ready = 1'b1;
   endtask

   // Full check of one access against the reference model.
   task automatic run_checked(input string tag, input logic we, input logic [2:0] size,
                              input int addr, input logic [31:0] wd, input int stalls);
      logic [31:0] rd, wdo, exp_rd;
      logic        err, we_bad, timeout, legal;
      int          stall_cyc, req_cyc;
      logic [3:0]  be;
      legal  = ref_legal(we, size, addr);
      exp_rd = (legal && !we) ? ref_load(size, addr) : 32'h0;
      do_access(we, size, 32'(addr), wd, stalls, rd, err, stall_cyc, req_cyc, be, wdo, we_bad, timeout);
      check({tag, "_timeout"}, 32'(timeout), 32'd0);
      check({tag, "_err"}, 32'(err), 32'(!legal));
      check({tag, "_stall"}, 32'(stall_cyc), legal ? 32'(1 + stalls) : 32'd0);
      check({tag, "_reqcyc"}, 32'(req_cyc), legal ? 32'(2 + stalls) : 32'd0);
      check({tag, "_rd"}, rd, exp_rd);
      if (legal) begin
         check({tag, "_we"}, 32'(we_bad), 32'd0);
         check({tag, "_be"}, 32'(be), we ? 32'(ref_be(size, addr)) : 32'hF);
         if (we) begin
            check({tag, "_wd"}, wdo, ref_wd(size, wd));
            ref_store(size, addr, wd);
         end
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        exp_err;
      logic [31:0] exp_rd;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
   } vec_t;

   vec_t tbl [12];

   initial begin
      logic [31:0] rd, wdo;
      logic        err, we_bad, timeout;
      int          stall_cyc, req_cyc;
      logic [3:0]  be;

      for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom_range(0, 255));
      {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]} = 32'h80FF_7F01;
      {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]} = 32'h1122_3344;

      tbl[0]  = '{1'b0, LDST_B,  32'h3, 32'h0,         1'b0, 32'hFFFF_FF80, 4'hF, 32'h0};
      tbl[1]  = '{1'b0, LDST_BU, 32'h3, 32'h0,         1'b0, 32'h0000_0080, 4'hF, 32'h0};
      tbl[2]  = '{1'b0, LDST_H,  32'h2, 32'h0,         1'b0, 32'hFFFF_80FF, 4'hF, 32'h0};
      tbl[3]  = '{1'b0, LDST_HU, 32'h0, 32'h0,         1'b0, 32'h0000_7F01, 4'hF, 32'h0};
      tbl[4]  = '{1'b0, LDST_W,  32'h0, 32'h0,         1'b0, 32'h80FF_7F01, 4'hF, 32'h0};
      tbl[5]  = '{1'b0, LDST_B,  32'h1, 32'h0,         1'b0, 32'h0000_007F, 4'hF, 32'h0};
      tbl[6]  = '{1'b1, LDST_B,  32'h5, 32'h1234_56AB, 1'b0, 32'h0,         4'b0010, 32'hABAB_ABAB};
      tbl[7]  = '{1'b0, LDST_W,  32'h4, 32'h0,         1'b0, 32'h1122_AB44, 4'hF, 32'h0};
      tbl[8]  = '{1'b1, LDST_H,  32'h1, 32'h0000_BEEF, 1'b1, 32'h0,         4'h0, 32'h0};
      tbl[9]  = '{1'b0, LDST_W,  32'h6, 32'h0,         1'b1, 32'h0,         4'h0, 32'h0};
      tbl[10] = '{1'b0, 3'd3,    32'h0, 32'h0,         1'b1, 32'h0,         4'h0, 32'h0};
      tbl[11] = '{1'b1, LDST_HU, 32'h0, 32'h0000_1234, 1'b1, 32'h0,         4'h0, 32'h0};

      // Reset: outputs forced low even with a legal request presented.
      rst = 1'b1; mem_ready = 1'b1;
      core_req = 1'b1; core_we = 1'b0; core_size = LDST_W; core_addr = 32'h0; core_wd = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_stall", 32'(core_stall), 32'd0);
      check("rst_err", 32'(core_err), 32'd0);
      check("rst_rd", core_rd, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; core_req = 1'b0;
      @(negedge clk);
      check("idle_mem_req", 32'(mem_req), 32'd0);
      check("idle_stall", 32'(core_stall), 32'd0);
      @(posedge clk); #1;

      // Directed table.
      for (int i = 0; i < 12; i++) begin
         do_access(tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wd, 0,
                   rd, err, stall_cyc, req_cyc, be, wdo, we_bad, timeout);
         check($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'd0);
         check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
         check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
         check($sformatf("tbl%0d_stall", i), 32'(stall_cyc), tbl[i].exp_err ? 32'd0 : 32'd1);
         check($sformatf("tbl%0d_reqcyc", i), 32'(req_cyc), tbl[i].exp_err ? 32'd0 : 32'd2);
         if (!tbl[i].exp_err) begin
            check($sformatf("tbl%0d_be", i), 32'(be), 32'(tbl[i].exp_be));
            check($sformatf("tbl%0d_we", i), 32'(we_bad), 32'd0);
            if (tbl[i].we) begin
               check($sformatf("tbl%0d_wd", i), wdo, tbl[i].exp_wd);
               ref_store(tbl[i].size, int'(tbl[i].addr), tbl[i].wd);
            end
         end
      end

      // Memory not ready for 3 cycles during a word load.
      run_checked("notready_lw", 1'b0, LDST_W, 0, 32'h0, 3);
      run_checked("notready_sh", 1'b1, LDST_H, 6, 32'hCAFE_5A5A, 2);

      // Core drops its request while in WAIT: bus released, back to IDLE.
      core_req = 1'b1; core_we = 1'b0; core_size = LDST_W; core_addr = 32'h4; core_wd = 32'h0;
      @(negedge clk);
      check("drop_issue_stall", 32'(core_stall), 32'd1);
      @(posedge clk); #1;
      core_req = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      check("drop_mem_req", 32'(mem_req), 32'd0);
      check("drop_stall", 32'(core_stall), 32'd0);
      @(posedge clk); #1;
      mem_ready = 1'b1;
      run_checked("after_drop", 1'b0, LDST_W, 0, 32'h0, 0);

      // Reset asserted while a load waits on the memory.
      core_req = 1'b1; core_we = 1'b0; core_size = LDST_W; core_addr = 32'h0; core_wd = 32'h0;
      @(negedge clk);
      check("rstwait_issue_stall", 32'(core_stall), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1; mem_ready = 1'b0;
      @(negedge clk);
      check("rstwait_mem_req", 32'(mem_req), 32'd0);
      check("rstwait_stall", 32'(core_stall), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; core_req = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      check("rstwait_next_mem_req", 32'(mem_req), 32'd0);
      check("rstwait_next_stall", 32'(core_stall), 32'd0);
      check("rstwait_next_rd", core_rd, 32'h0);
      @(posedge clk); #1;
      run_checked("after_rst", 1'b0, LDST_B, 3, 32'h0, 0);

      // Randomized accesses against the byte-level reference model.
      for (int k = 0; k < 250; k++) begin
         logic [2:0]  size;
         logic        we;
         int          addr;
         size = 3'($urandom_range(0, 7));
         we   = 1'($urandom_range(0, 1));
         addr = $urandom_range(0, 255);
         if ($urandom_range(0, 3) != 0) addr = addr - (addr % nbytes(size));
         run_checked($sformatf("rnd%0d", k), we, size, addr, $urandom, $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
